// File: rtl/rd_pkg.sv
// rd_pkg: shared mode encoding and count-width helper for the popcount pipeline.
package rd_pkg;
  typedef enum logic [1:0] {RD_MODE_BIT, RD_MODE_THR, RD_MODE_PAR, RD_MODE_ALL} rd_mode_e;
  function automatic int cw_of(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/rd_group_count.sv
// rd_group_count: combinational ones-count of a G-bit slice, CW-wide result.
module rd_group_count #(
  parameter int G  = 4,
  parameter int CW = 3
) (
  input  logic [G-1:0]  bits_i,
  output logic [CW-1:0] cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < G; i++) cnt_o = cnt_o + CW'(bits_i[i]);
  end
endmodule

// File: rtl/rd_popcount_pipe.sv
// rd_popcount_pipe: pipelined ones-count with a per-word derived bit and a
// single global advance shared by every stage, so bubbles are kept in place.
module rd_popcount_pipe import rd_pkg::*; #(
  parameter int  N_IN = 7,
  parameter int  PIPE = 2,
  localparam int CW   = cw_of(N_IN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_data,
  input  logic [1:0]      in_mode,
  input  logic [CW-1:0]   in_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW-1:0]   out_count,
  output logic            out_bit
);
  localparam int G  = (N_IN + PIPE - 1) / PIPE;
  localparam int NG = (N_IN + G - 1) / G;
  localparam int PW = NG * G;
  typedef logic [NG-1:0][CW-1:0] part_t;
  logic [PW-1:0]           din;
  part_t                   grp;
  part_t [PIPE-1:0]        p_q, p_d;
  part_t [PIPE:0]          pc;
  logic [PIPE-1:0][1:0]    m_q;
  logic [PIPE:0][1:0]      mc;
  logic [PIPE-1:0][CW-1:0] s_q;
  logic [PIPE:0][CW-1:0]   sc;
  logic [PIPE-1:0]         v_q;
  logic [PIPE:0]           vc;
  logic [CW-1:0]           sum_c, sh_c;
  logic                    bit_d, bit_q, adv;
  rd_mode_e                mode_l;
  assign din = PW'(in_data);
  genvar i;
  for (i = 0; i < NG; i++) begin : g_grp
    rd_group_count #(.G(G), .CW(CW)) u_grp (.bits_i(din[i*G +: G]), .cnt_o(grp[i]));
  end
  // Index 0 of each chain is the incoming word; index s+1 is stage s.
  assign pc = {p_q, grp};
  assign mc = {m_q, in_mode};
  assign sc = {s_q, in_sel};
  assign vc = {v_q, in_valid};
  assign adv = !v_q[PIPE-1] || out_ready;
  assign in_ready = adv;
  assign mode_l = rd_mode_e'(mc[PIPE-1]);
  // Stage 0 keeps the group partials; every later stage folds them into slot 0.
  always_comb begin
    sum_c = '0;
    for (int s = 0; s < PIPE; s++) begin
      sum_c = '0;
      for (int g = 0; g < NG; g++) sum_c = sum_c + pc[s][g];
      p_d[s] = (s == 0 && PIPE > 1) ? pc[s] : part_t'(sum_c);
    end
    sh_c  = p_d[PIPE-1][0] >> sc[PIPE-1];
    bit_d = mode_l == RD_MODE_BIT ? sh_c[0] :
            mode_l == RD_MODE_THR ? (p_d[PIPE-1][0] >= sc[PIPE-1]) :
            mode_l == RD_MODE_PAR ? p_d[PIPE-1][0][0] :
                                    (p_d[PIPE-1][0] == CW'(N_IN));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      m_q   <= '0;
      s_q   <= '0;
      v_q   <= '0;
      bit_q <= 1'b0;
    end else if (adv) begin
      p_q   <= p_d;
      m_q   <= mc[PIPE-1:0];
      s_q   <= sc[PIPE-1:0];
      v_q   <= vc[PIPE-1:0];
      bit_q <= bit_d;
    end
  end
  assign out_valid = v_q[PIPE-1];
  assign out_count = p_q[PIPE-1][0];
  assign out_bit   = bit_q;
endmodule

// File: tb/tb_rd_popcount_pipe.sv
// tb_rd_popcount_pipe: directed and random checks of two configurations
// (7-bit/2-stage and 16-bit/4-stage) against a queue-based reference model.
module tb_rd_popcount_pipe;
  localparam int NA = 7, PA = 2, CA = 3;
  localparam int NB = 16, PB = 4, CB = 5;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic a_iv = 0, a_ir, a_ov, a_or = 1, a_bit;
  logic [NA-1:0] a_d = '0;
  logic [1:0] a_m = '0;
  logic [CA-1:0] a_s = '0, a_cnt;
  logic b_iv = 0, b_ir, b_ov, b_or = 1, b_bit;
  logic [NB-1:0] b_d = '0;
  logic [1:0] b_m = '0;
  logic [CB-1:0] b_s = '0, b_cnt;
  rd_popcount_pipe #(.N_IN(NA), .PIPE(PA)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_d),
    .in_mode(a_m), .in_sel(a_s), .out_valid(a_ov), .out_ready(a_or),
    .out_count(a_cnt), .out_bit(a_bit));
  rd_popcount_pipe #(.N_IN(NB), .PIPE(PB)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_d),
    .in_mode(b_m), .in_sel(b_s), .out_valid(b_ov), .out_ready(b_or),
    .out_count(b_cnt), .out_bit(b_bit));
  typedef struct { int cnt; int b; int cyc; } exp_t;
  exp_t qa[$], qb[$];
  int errs = 0, checks = 0, cyc = 0;
  bit lat_chk = 1, a_stall = 0, b_stall = 0, a_took = 0, b_took = 0;
  int pa_cnt = 0, pa_bit = 0, pb_cnt = 0, pb_bit = 0;
  function automatic int ref_bit(input int cnt, input int mode, input int sel, input int n, input int cw);
    return mode == 0 ? (sel >= cw ? 0 : (cnt / (1 << sel)) % 2) :
           mode == 1 ? int'(cnt >= sel) :
           mode == 2 ? cnt % 2 : int'(cnt == n);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  // One clock cycle: settle, check outputs against the model, record accepts, advance.
  task automatic tick();
    exp_t e;
    #1;
    chk("a_in_ready", 32'(a_ir), 32'(!a_ov || a_or));
    if (a_stall) begin
      chk("a_hold_valid", 32'(a_ov), 1);
      chk("a_hold_count", 32'(a_cnt), pa_cnt);
      chk("a_hold_bit", 32'(a_bit), pa_bit);
    end
    if (a_ov && a_or) begin
      if (qa.size() == 0) chk("a_spurious_valid", 32'(a_ov), 0);
      else begin
        e = qa.pop_front();
        chk("a_count", 32'(a_cnt), e.cnt);
        chk("a_bit", 32'(a_bit), e.b);
        if (lat_chk) chk("a_latency", cyc - e.cyc, PA);
      end
    end
    a_stall = a_ov && !a_or; pa_cnt = int'(a_cnt); pa_bit = int'(a_bit);
    a_took = a_iv && a_ir;
    if (a_took) qa.push_back('{cnt: $countones(a_d), b: ref_bit($countones(a_d), a_m, a_s, NA, CA), cyc: cyc});
    chk("b_in_ready", 32'(b_ir), 32'(!b_ov || b_or));
    if (b_stall) begin
      chk("b_hold_valid", 32'(b_ov), 1);
      chk("b_hold_count", 32'(b_cnt), pb_cnt);
      chk("b_hold_bit", 32'(b_bit), pb_bit);
    end
    if (b_ov && b_or) begin
      if (qb.size() == 0) chk("b_spurious_valid", 32'(b_ov), 0);
      else begin
        e = qb.pop_front();
        chk("b_count", 32'(b_cnt), e.cnt);
        chk("b_bit", 32'(b_bit), e.b);
        if (lat_chk) chk("b_latency", cyc - e.cyc, PB);
      end
    end
    b_stall = b_ov && !b_or; pb_cnt = int'(b_cnt); pb_bit = int'(b_bit);
    b_took = b_iv && b_ir;
    if (b_took) qb.push_back('{cnt: $countones(b_d), b: ref_bit($countones(b_d), b_m, b_s, NB, CB), cyc: cyc});
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask
  // Send one word, optionally change mode after acceptance, then check fixed expectations.
  task automatic dir(input bit on_b, input logic [15:0] d, input int m, input int s,
                     input int ec, input int eb, input int m2);
    if (on_b) begin b_d = d; b_m = 2'(m); b_s = CB'(s); b_iv = 1; end
    else begin a_d = d[NA-1:0]; a_m = 2'(m); a_s = CA'(s); a_iv = 1; end
    tick();
    if (on_b) begin b_iv = 0; b_m = 2'(m2); b_s = CB'(s + 1); end
    else begin a_iv = 0; a_m = 2'(m2); a_s = CA'(s + 1); end
    for (int k = 0; k < 8 && !(on_b ? b_ov : a_ov); k++) tick();
    #1;
    chk("dir_valid", 32'(on_b ? b_ov : a_ov), 1);
    chk("dir_count", on_b ? 32'(b_cnt) : 32'(a_cnt), ec);
    chk("dir_bit", 32'(on_b ? b_bit : a_bit), eb);
    tick();
  endtask
  initial begin
    int sent, guard;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_valid", 32'(a_ov), 0);
    chk("rst_count", 32'(a_cnt), 0);
    chk("rst_bit", 32'(a_bit), 0);
    chk("rst_in_ready", 32'(a_ir), 1);
    chk("rst_b_valid", 32'(b_ov), 0);
    rst_n = 1;
    // Exhaustive rd73f1: every 7-bit word back to back, count bit 1.
    a_m = 0; a_s = 1;
    for (int w = 0; w < 128; w++) begin a_iv = 1; a_d = NA'(w); tick(); end
    a_iv = 0;
    repeat (4) tick();
    chk("exh_drained", qa.size(), 0);
    // Backpressure holds the first result and blocks the third word.
    lat_chk = 0;
    a_iv = 1; a_d = 7'h01; tick();
    a_d = 7'h03; tick();
    a_or = 0; a_d = 7'h07;
    repeat (5) begin
      #1;
      chk("bp_in_ready", 32'(a_ir), 0);
      chk("bp_count", 32'(a_cnt), 1);
      tick();
    end
    a_or = 1; tick();
    a_iv = 0;
    repeat (6) tick();
    chk("bp_drained", qa.size(), 0);
    lat_chk = 1;
    dir(0, 16'h7F, 0, 1, 7, 1, 0);
    dir(0, 16'h0F, 0, 1, 4, 0, 0);
    dir(0, 16'h15, 1, 3, 3, 1, 1);
    dir(0, 16'h15, 1, 4, 3, 0, 1);
    dir(0, 16'h15, 1, 0, 3, 1, 1);
    dir(0, 16'h15, 2, 0, 3, 1, 2);
    dir(0, 16'h7F, 3, 0, 7, 1, 3);
    dir(0, 16'h7E, 3, 0, 6, 0, 3);
    dir(0, 16'h7F, 0, 5, 7, 0, 0);
    // Mode/sel change after acceptance must not affect the word in flight.
    dir(0, 16'h7F, 0, 2, 7, 1, 2);
    dir(0, 16'h0F, 0, 2, 4, 1, 2);
    // Asynchronous reset with two words in flight.
    a_or = 0; a_iv = 1; a_d = 7'h7F; a_m = 0; a_s = 0; tick();
    a_d = 7'h3F; tick();
    a_iv = 0;
    #1;
    chk("pre_rst_valid", 32'(a_ov), 1);
    chk("pre_rst_count", 32'(a_cnt), 7);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", 32'(a_ov), 0);
    chk("mid_rst_count", 32'(a_cnt), 0);
    chk("mid_rst_bit", 32'(a_bit), 0);
    @(negedge clk);
    rst_n = 1; a_or = 1; a_stall = 0; qa.delete();
    repeat (5) begin #1; chk("post_rst_no_stale", 32'(a_ov), 0); tick(); end
    // Wide configuration.
    dir(1, 16'hFFFF, 3, 0, 16, 1, 3);
    dir(1, 16'h8001, 0, 1, 2, 1, 0);
    dir(1, 16'h8001, 3, 0, 2, 0, 3);
    lat_chk = 0; sent = 0; guard = 0;
    while (sent < 1000 && guard < 20000) begin
      if (!b_iv || b_took) begin
        b_iv = $urandom_range(0, 3) != 0;
        b_d = NB'($urandom);
        b_m = 2'($urandom_range(0, 3));
        b_s = CB'($urandom_range(0, 31));
      end
      b_or = $urandom_range(0, 3) != 0;
      tick();
      if (b_took) sent++;
      guard++;
    end
    if (sent < 1000) chk("rand_cycle_budget", sent, 1000);
    b_iv = 0; b_or = 1;
    repeat (8) tick();
    chk("rand_drained", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
